biu_arbiter: RTL and testbench

//  Shares the single BIU line-request port between N_REQ requesters (I-cache

---
 rtl/biu_arbiter.sv | 178 +++++++++++++++++
 tb/tb_biu_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biu_arbiter.sv
// biu_arbiter
//   Shares one BIU line-request port between N_REQ requesters. Requests are
//   granted round-robin. Only one line transaction is in flight at a time.
//   A read response is buffered and handed back to the requester that owns it.
//   A write is complete as soon as the BIU accepts it; the BIU sends no response.
//
//   Parameters
//     N_REQ   number of requesters (>=2); index 0 has top priority after reset
//     ADDR_W  request address width
//     LINE_W  cache line width, equal to the BIU data path
//
//   Ports
//     clk, rst            rising-edge clock; synchronous active-high reset
//     cli_req_vld_i       per-requester request valid, held until acked
//     cli_req_ack_o       one-hot, 1-cycle pulse when a request is captured
//     cli_req_rd_i        per-requester direction: 1 = read line, 0 = write line
//     cli_req_addr_i      packed addresses; requester k at [k*ADDR_W +: ADDR_W]
//     cli_req_wdata_i     packed write lines; requester k at [k*LINE_W +: LINE_W]
//     cli_resp_vld_o      one-hot read-response valid for the owning requester
//     cli_resp_ack_i      owner consumes the response; other bits are ignored
//     cli_resp_rdata_o    shared read-data bus, qualified by cli_resp_vld_o
//     cli_resp_err_o      error flag of the buffered response
//     biu_req_*           request channel to the BIU (biu_req_ack_i is level ready)
//     biu_resp_*          response channel from the BIU
module biu_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 64,
  parameter int LINE_W = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        cli_req_vld_i,
  output logic [N_REQ-1:0]        cli_req_ack_o,
  input  logic [N_REQ-1:0]        cli_req_rd_i,
  input  logic [N_REQ*ADDR_W-1:0] cli_req_addr_i,
  input  logic [N_REQ*LINE_W-1:0] cli_req_wdata_i,
  output logic [N_REQ-1:0]        cli_resp_vld_o,
  input  logic [N_REQ-1:0]        cli_resp_ack_i,
  output logic [LINE_W-1:0]       cli_resp_rdata_o,
  output logic                    cli_resp_err_o,
  output logic                    biu_req_vld_o,
  input  logic                    biu_req_ack_i,
  output logic                    biu_req_rd_o,
  output logic [ADDR_W-1:0]       biu_req_addr_o,
  output logic [LINE_W-1:0]       biu_req_wdata_o,
  input  logic                    biu_resp_vld_i,
  output logic                    biu_resp_ack_o,
  input  logic [LINE_W-1:0]       biu_resp_rdata_i,
  input  logic                    biu_resp_err_i
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    RESP      = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   prio_ptr_q, prio_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic               rd_q, rd_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;
  logic [LINE_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [PTR_W-1:0]   winner;
  logic               win_vld;
  logic [ADDR_W-1:0]  req_addr  [N_REQ];
  logic [LINE_W-1:0]  req_wdata [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign req_addr[k]  = cli_req_addr_i[k*ADDR_W +: ADDR_W];
    assign req_wdata[k] = cli_req_wdata_i[k*LINE_W +: LINE_W];
  end

  // Round-robin pick. The first pass finds the lowest requesting index
  // overall; this covers the wrap-around case. The second pass overrides that
  // with the lowest requesting index at or above prio_ptr_q, if there is one.
  // Both loops run downward so the last hit is the lowest index.
  always_comb begin
    winner  = '0;
    win_vld = 1'b0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (cli_req_vld_i[j]) begin
        winner  = PTR_W'(j);
        win_vld = 1'b1;
      end
    end
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (cli_req_vld_i[j] && (PTR_W'(j) >= prio_ptr_q)) begin
        winner = PTR_W'(j);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    prio_ptr_d     = prio_ptr_q;
    owner_d        = owner_q;
    rd_d           = rd_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    cli_req_ack_o  = '0;
    cli_resp_vld_o = '0;
    biu_req_vld_o  = 1'b0;
    biu_resp_ack_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          cli_req_ack_o[winner] = 1'b1;
          owner_d    = winner;
          rd_d       = cli_req_rd_i[winner];
          addr_d     = req_addr[winner];
          wdata_d    = req_wdata[winner];
          // Explicit wrap, so a non-power-of-two N_REQ also works.
          prio_ptr_d = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        biu_req_vld_o = 1'b1;
        if (biu_req_ack_i) begin
          state_d = rd_q ? WAIT_RESP : IDLE;
        end
      end
      WAIT_RESP: begin
        biu_resp_ack_o = 1'b1;
        if (biu_resp_vld_i) begin
          rdata_d = biu_resp_rdata_i;
          err_d   = biu_resp_err_i;
          state_d = RESP;
        end
      end
      RESP: begin
        cli_resp_vld_o[owner_q] = 1'b1;
        if (cli_resp_ack_i[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_ptr_q <= '0;
      owner_q    <= '0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_ptr_q <= prio_ptr_d;
      owner_q    <= owner_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign biu_req_rd_o     = rd_q;
  assign biu_req_addr_o   = addr_q;
  assign biu_req_wdata_o  = wdata_q;
  assign cli_resp_rdata_o = rdata_q;
  assign cli_resp_err_o   = err_q;

endmodule

// File: tb/tb_biu_arbiter.sv
// tb_biu_arbiter
//   Testbench for biu_arbiter. The stimulus side plays the requesters and the
//   BIU. A transaction-level reference model runs alongside. It keeps a
//   round-robin pointer, a queue of granted requests waiting to be issued and a
//   queue of read responses owed to the requesters. A negedge monitor compares
//   every DUT output against the heads of those queues.
module tb_biu_arbiter;

  localparam int N_REQ  = 2;
  localparam int ADDR_W = 64;
  localparam int LINE_W = 512;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        cli_req_vld_i;
  logic [N_REQ-1:0]        cli_req_ack_o;
  logic [N_REQ-1:0]        cli_req_rd_i;
  logic [N_REQ*ADDR_W-1:0] cli_req_addr_i;
  logic [N_REQ*LINE_W-1:0] cli_req_wdata_i;
  logic [N_REQ-1:0]        cli_resp_vld_o;
  logic [N_REQ-1:0]        cli_resp_ack_i;
  logic [LINE_W-1:0]       cli_resp_rdata_o;
  logic                    cli_resp_err_o;
  logic                    biu_req_vld_o;
  logic                    biu_req_ack_i;
  logic                    biu_req_rd_o;
  logic [ADDR_W-1:0]       biu_req_addr_o;
  logic [LINE_W-1:0]       biu_req_wdata_o;
  logic                    biu_resp_vld_i;
  logic                    biu_resp_ack_o;
  logic [LINE_W-1:0]       biu_resp_rdata_i;
  logic                    biu_resp_err_i;

  biu_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .cli_req_vld_i(cli_req_vld_i), .cli_req_ack_o(cli_req_ack_o),
    .cli_req_rd_i(cli_req_rd_i), .cli_req_addr_i(cli_req_addr_i),
    .cli_req_wdata_i(cli_req_wdata_i), .cli_resp_vld_o(cli_resp_vld_o),
    .cli_resp_ack_i(cli_resp_ack_i), .cli_resp_rdata_o(cli_resp_rdata_o),
    .cli_resp_err_o(cli_resp_err_o), .biu_req_vld_o(biu_req_vld_o),
    .biu_req_ack_i(biu_req_ack_i), .biu_req_rd_o(biu_req_rd_o),
    .biu_req_addr_o(biu_req_addr_o), .biu_req_wdata_o(biu_req_wdata_o),
    .biu_resp_vld_i(biu_resp_vld_i), .biu_resp_ack_o(biu_resp_ack_o),
    .biu_resp_rdata_i(biu_resp_rdata_i), .biu_resp_err_i(biu_resp_err_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    int                owner;
  } iss_t;

  typedef struct {
    int                owner;
    logic [LINE_W-1:0] rdata;
    logic              err;
  } resp_t;

  // reference model state
  iss_t  iss_q[$];
  resp_t resp_q[$];
  int    ptr        = 0;
  bit    busy       = 1'b0;
  bit    wait_rd    = 1'b0;
  int    wait_owner = 0;
  bit    post_rst   = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // handshakes the DUT showed at the last negedge, for the stimulus side
  logic [N_REQ-1:0] seen_ack    = '0;
  logic             seen_accept = 1'b0;
  logic             seen_bresp  = 1'b0;

  // requester and BIU behaviour state
  bit                req_act   [N_REQ];
  bit                req_rd    [N_REQ];
  logic [ADDR_W-1:0] req_addr  [N_REQ];
  logic [LINE_W-1:0] req_wdata [N_REQ];
  bit                bpend = 1'b0;
  int                bdly  = 0;
  logic [LINE_W-1:0] bdata;
  logic              berr;

  task automatic chk(input string name, input logic [LINE_W-1:0] act,
                     input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int model_winner(input logic [N_REQ-1:0] v);
    int k;
    for (int i = 0; i < N_REQ; i++) begin
      k = (ptr + i) % N_REQ;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  always @(negedge clk) begin : monitor
    logic [N_REQ-1:0] exp_ack;
    logic [N_REQ-1:0] exp_rv;
    int               w;
    iss_t             it;
    resp_t            rt;
    w = busy ? -1 : model_winner(cli_req_vld_i);
    exp_ack = '0;
    if (w >= 0) exp_ack[w] = 1'b1;
    chk("cli_req_ack", cli_req_ack_o, exp_ack);
    chk("biu_req_vld", biu_req_vld_o, iss_q.size() != 0);
    if (iss_q.size() != 0) begin
      chk("biu_req_rd", biu_req_rd_o, iss_q[0].rd);
      chk("biu_req_addr", biu_req_addr_o, iss_q[0].addr);
      chk("biu_req_wdata", biu_req_wdata_o, iss_q[0].wdata);
    end
    chk("biu_resp_ack", biu_resp_ack_o, wait_rd);
    exp_rv = '0;
    if (resp_q.size() != 0) exp_rv[resp_q[0].owner] = 1'b1;
    chk("cli_resp_vld", cli_resp_vld_o, exp_rv);
    if (resp_q.size() != 0) begin
      chk("cli_resp_rdata", cli_resp_rdata_o, resp_q[0].rdata);
      chk("cli_resp_err", cli_resp_err_o, resp_q[0].err);
    end
    if (post_rst) begin
      chk("rst_biu_req_rd", biu_req_rd_o, 1'b0);
      chk("rst_biu_req_addr", biu_req_addr_o, '0);
      chk("rst_biu_req_wdata", biu_req_wdata_o, '0);
      chk("rst_cli_resp_rdata", cli_resp_rdata_o, '0);
      chk("rst_cli_resp_err", cli_resp_err_o, 1'b0);
      post_rst = 1'b0;
    end

    seen_ack    = cli_req_ack_o;
    seen_accept = biu_req_vld_o & biu_req_ack_i & biu_req_rd_o;
    seen_bresp  = biu_resp_vld_i & biu_resp_ack_o;

    if (rst) begin
      iss_q.delete();
      resp_q.delete();
      ptr      = 0;
      busy     = 1'b0;
      wait_rd  = 1'b0;
      post_rst = 1'b1;
    end else begin
      if (resp_q.size() != 0 && cli_resp_ack_i[resp_q[0].owner]) begin
        void'(resp_q.pop_front());
        busy = 1'b0;
      end
      if (wait_rd && biu_resp_vld_i) begin
        rt.owner = wait_owner;
        rt.rdata = biu_resp_rdata_i;
        rt.err   = biu_resp_err_i;
        resp_q.push_back(rt);
        wait_rd = 1'b0;
      end
      if (iss_q.size() != 0 && biu_req_ack_i) begin
        it = iss_q.pop_front();
        if (it.rd) begin
          wait_rd    = 1'b1;
          wait_owner = it.owner;
        end else begin
          busy = 1'b0;
        end
      end
      if (w >= 0) begin
        it.rd    = cli_req_rd_i[w];
        it.addr  = cli_req_addr_i[w*ADDR_W +: ADDR_W];
        it.wdata = cli_req_wdata_i[w*LINE_W +: LINE_W];
        it.owner = w;
        iss_q.push_back(it);
        ptr  = (w + 1) % N_REQ;
        busy = 1'b1;
      end
    end
  end

  task automatic clear_inputs();
    cli_req_vld_i    = '0;
    cli_req_rd_i     = '0;
    cli_req_addr_i   = '0;
    cli_req_wdata_i  = '0;
    cli_resp_ack_i   = '0;
    biu_req_ack_i    = 1'b0;
    biu_resp_vld_i   = 1'b0;
    biu_resp_rdata_i = '0;
    biu_resp_err_i   = 1'b0;
  endtask

  task automatic dir_read(input int k, input logic [ADDR_W-1:0] a,
                          input logic [LINE_W-1:0] d, input logic e, input int stall);
    @(posedge clk); #1;
    cli_req_vld_i = '0;
    cli_req_vld_i[k] = 1'b1;
    cli_req_rd_i[k]  = 1'b1;
    cli_req_addr_i[k*ADDR_W +: ADDR_W] = a;
    @(posedge clk); #1;
    cli_req_vld_i = '0;
    repeat (stall) begin @(posedge clk); #1; end
    biu_req_ack_i = 1'b1;
    @(posedge clk); #1;
    biu_req_ack_i    = 1'b0;
    biu_resp_vld_i   = 1'b1;
    biu_resp_rdata_i = d;
    biu_resp_err_i   = e;
    @(posedge clk); #1;
    biu_resp_vld_i   = 1'b0;
    biu_resp_rdata_i = rand_line();
    cli_resp_ack_i   = ~(N_REQ'(1) << k);
    repeat (stall) begin @(posedge clk); #1; end
    cli_resp_ack_i = '0;
    cli_resp_ack_i[k] = 1'b1;
    @(posedge clk); #1;
    cli_resp_ack_i = '0;
  endtask

  task automatic dir_write(input int k, input logic [ADDR_W-1:0] a,
                           input logic [LINE_W-1:0] d, input int stall);
    @(posedge clk); #1;
    cli_req_vld_i = '0;
    cli_req_vld_i[k] = 1'b1;
    cli_req_rd_i[k]  = 1'b0;
    cli_req_addr_i[k*ADDR_W +: ADDR_W]  = a;
    cli_req_wdata_i[k*LINE_W +: LINE_W] = d;
    @(posedge clk); #1;
    cli_req_vld_i = '0;
    repeat (stall) begin @(posedge clk); #1; end
    biu_req_ack_i = 1'b1;
    @(posedge clk); #1;
    biu_req_ack_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic drive_random();
    for (int k = 0; k < N_REQ; k++) begin
      if (seen_ack[k]) req_act[k] = 1'b0;
      else if (req_act[k] && $urandom_range(0, 99) < 2) req_act[k] = 1'b0;
      if (!req_act[k] && $urandom_range(0, 99) < 40) begin
        req_act[k]   = 1'b1;
        req_rd[k]    = $urandom_range(0, 1) != 0;
        req_addr[k]  = {$urandom, $urandom & 32'hFFFF_FFC0};
        req_wdata[k] = rand_line();
      end
      cli_req_vld_i[k] = req_act[k];
      cli_req_rd_i[k]  = req_rd[k];
      cli_req_addr_i[k*ADDR_W +: ADDR_W]  = req_addr[k];
      cli_req_wdata_i[k*LINE_W +: LINE_W] = req_wdata[k];
    end
    biu_req_ack_i = $urandom_range(0, 2) != 0;
    if (seen_bresp) bpend = 1'b0;
    if (seen_accept) begin
      bpend = 1'b1;
      bdly  = $urandom_range(0, 3);
      bdata = rand_line();
      berr  = $urandom_range(0, 3) == 0;
    end
    if (bpend) begin
      if (bdly > 0) begin
        bdly--;
        biu_resp_vld_i = 1'b0;
      end else begin
        biu_resp_vld_i   = 1'b1;
        biu_resp_rdata_i = bdata;
        biu_resp_err_i   = berr;
      end
    end else begin
      // stray response traffic while no read is outstanding
      biu_resp_vld_i   = $urandom_range(0, 7) == 0;
      biu_resp_rdata_i = rand_line();
      biu_resp_err_i   = $urandom_range(0, 1) != 0;
    end
    cli_resp_ack_i = N_REQ'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    for (int k = 0; k < N_REQ; k++) begin
      req_act[k] = 1'b0; req_rd[k] = 1'b0; req_addr[k] = '0; req_wdata[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    dir_read(0, 64'h1000, {16{32'hA5A5_A5A5}}, 1'b0, 3);
    dir_write(1, 64'h2040, rand_line(), 5);
    dir_read(1, 64'h3000, rand_line(), 1'b1, 0);

    // reset while a read waits for its response
    @(posedge clk); #1;
    cli_req_vld_i = N_REQ'(1);
    cli_req_rd_i  = N_REQ'(1);
    cli_req_addr_i[0 +: ADDR_W] = 64'h4000;
    biu_req_ack_i = 1'b1;
    @(posedge clk); #1;
    cli_req_vld_i = '0;
    @(posedge clk); #1;
    biu_req_ack_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();

    // both requesters at once straight after reset: requester 0 must win
    for (int k = 0; k < N_REQ; k++) begin
      req_act[k]   = 1'b1;
      req_rd[k]    = 1'b0;
      req_addr[k]  = 64'h8000 + 64'(k) * 64'h40;
      req_wdata[k] = rand_line();
    end
    bpend = 1'b0;
    repeat (3000) begin
      @(posedge clk); #1;
      drive_random();
    end
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
